// File: rtl/vga_capture.sv
// vga_capture
//   Receive side of the VGA output path. Samples HSYNC/VSYNC/RGB565 from a VGA
//   timing source on the pixel clock. From the syncs it recovers the horizontal
//   and vertical position, checks every line and frame period against the
//   configured mode, and emits the active pixels with x/y coordinates once the
//   incoming timing has been verified for LOCK_FRAMES consecutive frames.
//
// Ports
//   clk_pll      in   pixel clock, all logic on the rising edge
//   rst          in   synchronous reset, active low
//   HSYNC_IN     in   horizontal sync, polarity set by SYNC_POL
//   VSYNC_IN     in   vertical sync, polarity set by SYNC_POL
//   RED_IN       in   5-bit red sample
//   GREEN_IN     in   6-bit green sample
//   BLUE_IN      in   5-bit blue sample
//   pixel_valid  out  pixel_data/pixel_x/pixel_y valid this cycle
//   pixel_data   out  {R,G,B} RGB565, held while pixel_valid is low
//   pixel_x      out  0..H_PIXELS-1
//   pixel_y      out  0..V_LINES-1
//   frame_start  out  1-cycle pulse together with pixel (0,0)
//   locked       out  high while the timing is verified
//   sync_err     out  1-cycle pulse on a line or frame period mismatch
//   err_count    out  saturating count of sync_err pulses
module vga_capture #(
  parameter int H_PIXELS     = 800,
  parameter int H_FRONTPORCH = 40,
  parameter int H_SYNCTIME   = 128,
  parameter int H_BACKPORCH  = 88,
  parameter int V_LINES      = 600,
  parameter int V_FRONTPORCH = 1,
  parameter int V_SYNCTIME   = 4,
  parameter int V_BACKPORCH  = 23,
  parameter int SYNC_POL     = 1,
  parameter int LOCK_FRAMES  = 2,
  parameter int X_BITS       = 11,
  parameter int Y_BITS       = 10
) (
  input  logic              clk_pll,
  input  logic              rst,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  input  logic [4:0]        RED_IN,
  input  logic [5:0]        GREEN_IN,
  input  logic [4:0]        BLUE_IN,
  output logic              pixel_valid,
  output logic [15:0]       pixel_data,
  output logic [X_BITS-1:0] pixel_x,
  output logic [Y_BITS-1:0] pixel_y,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err,
  output logic [7:0]        err_count
);

  localparam int H_TOTAL = H_PIXELS + H_FRONTPORCH + H_SYNCTIME + H_BACKPORCH;
  localparam int V_TOTAL = V_LINES + V_FRONTPORCH + V_SYNCTIME + V_BACKPORCH;

  localparam logic [X_BITS-1:0] H_MAX   = '1;
  localparam logic [X_BITS-1:0] H_LAST  = X_BITS'(H_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_FIRST = X_BITS'(H_SYNCTIME + H_BACKPORCH);
  localparam logic [X_BITS-1:0] H_END   = X_BITS'(H_SYNCTIME + H_BACKPORCH + H_PIXELS - 1);
  localparam logic [Y_BITS-1:0] V_MAX   = '1;
  localparam logic [Y_BITS-1:0] V_LAST  = Y_BITS'(V_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_FIRST = Y_BITS'(V_SYNCTIME + V_BACKPORCH);
  localparam logic [Y_BITS-1:0] V_END   = Y_BITS'(V_SYNCTIME + V_BACKPORCH + V_LINES - 1);
  localparam logic [7:0]        LOCK_CNT = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // Stage 1: input registers, syncs normalised to active-high
  logic        hs_norm, vs_norm;
  logic        hs_reg, hs_d_reg, vs_reg, vs_d_reg;
  logic [15:0] rgb_reg;

  assign hs_norm = (SYNC_POL != 0) ? HSYNC_IN : ~HSYNC_IN;
  assign vs_norm = (SYNC_POL != 0) ? VSYNC_IN : ~VSYNC_IN;

  // Sync history resets to "asserted" so that leaving reset in the middle of
  // a sync pulse does not fake an edge; the next real edge is the first one.
  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      hs_reg   <= 1'b1;
      hs_d_reg <= 1'b1;
      vs_reg   <= 1'b1;
      vs_d_reg <= 1'b1;
      rgb_reg  <= '0;
    end else begin
      hs_reg   <= hs_norm;
      hs_d_reg <= hs_reg;
      vs_reg   <= vs_norm;
      vs_d_reg <= vs_reg;
      rgb_reg  <= {RED_IN, GREEN_IN, BLUE_IN};
    end
  end

  // Position counters. h_next/v_next is the position of the sample currently
  // held in rgb_reg, so the active window and coordinates line up with it.
  logic              hs_edge, vs_edge;
  logic [X_BITS-1:0] h_cnt_reg, h_next, x_next;
  logic [Y_BITS-1:0] v_cnt_reg, v_next, y_next;
  logic              h_seen_reg, v_seen_reg;
  logic              line_err, frame_err, any_err, saturated, active;

  assign hs_edge = hs_reg & ~hs_d_reg;
  assign vs_edge = vs_reg & ~vs_d_reg;

  always_comb begin
    h_next = h_cnt_reg;
    v_next = v_cnt_reg;
    if (hs_edge)
      h_next = '0;
    else if (h_cnt_reg != H_MAX)
      h_next = h_cnt_reg + 1'b1;
    // A vs edge wins over a coincident hs edge
    if (vs_edge)
      v_next = '0;
    else if (hs_edge && v_cnt_reg != V_MAX)
      v_next = v_cnt_reg + 1'b1;
  end

  // Period checks are skipped until one edge of each kind has been seen
  assign line_err  = hs_edge & h_seen_reg & (h_cnt_reg != H_LAST);
  assign frame_err = vs_edge & v_seen_reg & (v_cnt_reg != V_LAST);
  assign any_err   = line_err | frame_err;
  assign saturated = (h_next == H_MAX) | (v_next == V_MAX);
  assign active    = (h_next >= H_FIRST) && (h_next <= H_END) &&
                     (v_next >= V_FIRST) && (v_next <= V_END);
  assign x_next    = h_next - H_FIRST;
  assign y_next    = v_next - V_FIRST;

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      h_seen_reg <= 1'b0;
      v_seen_reg <= 1'b0;
    end else begin
      h_cnt_reg  <= h_next;
      v_cnt_reg  <= v_next;
      h_seen_reg <= h_seen_reg | hs_edge;
      v_seen_reg <= v_seen_reg | vs_edge;
    end
  end

  // Lock FSM
  state_t     state_reg, state_next;
  logic [7:0] good_reg, good_next, good_inc;

  assign good_inc = good_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    case (state_reg)
      SEARCH: begin
        if (vs_edge) begin
          state_next = VERIFY;
          good_next  = 8'd0;
        end
      end
      VERIFY: begin
        if (any_err) begin
          state_next = SEARCH;
        end else if (vs_edge) begin
          good_next = good_inc;
          if (good_inc >= LOCK_CNT)
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err)
          state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
    // Lost sync (a counter ran out) always restarts the search
    if (saturated)
      state_next = SEARCH;
  end

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      state_reg <= SEARCH;
      good_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  assign locked = (state_reg == LOCKED);

  // Stage 2: output registers. Gating with state_next keeps pixel_valid in
  // step with locked, so both drop together the cycle after an error.
  logic valid_next;
  assign valid_next = active & (state_next == LOCKED);

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      pixel_valid <= valid_next;
      if (valid_next) begin
        pixel_data <= rgb_reg;
        pixel_x    <= x_next;
        pixel_y    <= y_next;
      end
      frame_start <= valid_next && (x_next == '0) && (y_next == '0);
      sync_err    <= any_err;
      if (any_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a reduced video mode (8x4 active, 15x9 total)
// so whole frames run in a few hundred clocks. Two instances run side by
// side: one with active-high syncs, one with active-low syncs fed the inverted
// sync pins; both are held to the same expectations.
module tb_vga_capture;

  localparam int H_PIX = 8, H_FP = 2, H_SY = 3, H_BP = 2;
  localparam int V_LN  = 4, V_FP = 1, V_SY = 2, V_BP = 2;
  localparam int LOCK  = 2, XB = 5, YB = 4;
  localparam int H_TOT = H_PIX + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_LN + V_FP + V_SY + V_BP;
  localparam int H_ST  = H_SY + H_BP;
  localparam int V_ST  = V_SY + V_BP;
  localparam int H_MX  = (1 << XB) - 1;
  localparam int V_MX  = (1 << YB) - 1;
  localparam int CLK_P = 10;
  // pins set 1 time unit after an edge, outputs sampled on the falling edge
  // two clocks later
  localparam int LAT   = 2 * CLK_P + CLK_P / 2 - 1;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    longint      t;
  } pix_t;

  typedef struct packed {
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  logic       clk_pll = 1'b0;
  logic       rst = 1'b0;
  logic       hs_pin = 1'b0, vs_pin = 1'b0, hs_pin_n = 1'b1, vs_pin_n = 1'b1;
  logic [4:0] red = '0, blue = '0;
  logic [5:0] green = '0;

  logic          pv0, fs0, lk0, se0, pv1, fs1, lk1, se1;
  logic [15:0]   pd0, pd1;
  logic [XB-1:0] px0, px1;
  logic [YB-1:0] py0, py1;
  logic [7:0]    ec0, ec1;

  always #(CLK_P / 2) clk_pll = ~clk_pll;

  vga_capture #(
    .H_PIXELS(H_PIX), .H_FRONTPORCH(H_FP), .H_SYNCTIME(H_SY), .H_BACKPORCH(H_BP),
    .V_LINES(V_LN), .V_FRONTPORCH(V_FP), .V_SYNCTIME(V_SY), .V_BACKPORCH(V_BP),
    .SYNC_POL(1), .LOCK_FRAMES(LOCK), .X_BITS(XB), .Y_BITS(YB)
  ) dut0 (
    .clk_pll(clk_pll), .rst(rst), .HSYNC_IN(hs_pin), .VSYNC_IN(vs_pin),
    .RED_IN(red), .GREEN_IN(green), .BLUE_IN(blue),
    .pixel_valid(pv0), .pixel_data(pd0), .pixel_x(px0), .pixel_y(py0),
    .frame_start(fs0), .locked(lk0), .sync_err(se0), .err_count(ec0)
  );

  vga_capture #(
    .H_PIXELS(H_PIX), .H_FRONTPORCH(H_FP), .H_SYNCTIME(H_SY), .H_BACKPORCH(H_BP),
    .V_LINES(V_LN), .V_FRONTPORCH(V_FP), .V_SYNCTIME(V_SY), .V_BACKPORCH(V_BP),
    .SYNC_POL(0), .LOCK_FRAMES(LOCK), .X_BITS(XB), .Y_BITS(YB)
  ) dut1 (
    .clk_pll(clk_pll), .rst(rst), .HSYNC_IN(hs_pin_n), .VSYNC_IN(vs_pin_n),
    .RED_IN(red), .GREEN_IN(green), .BLUE_IN(blue),
    .pixel_valid(pv1), .pixel_data(pd1), .pixel_x(px1), .pixel_y(py1),
    .frame_start(fs1), .locked(lk1), .sync_err(se1), .err_count(ec1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, advanced once per pin cycle by the driver
  int   m_state = 0;           // 0 search, 1 verify, 2 locked
  int   m_good = 0, m_h = 0, m_v = 0, m_ecnt = 0;
  bit   m_hseen = 0, m_vseen = 0, m_hsp = 1, m_vsp = 1;
  exp_t e_pin = '0, e1 = '0, e2 = '0;
  logic rst_q = 1'b0;
  pix_t q0[$], q1[$];
  int   n_valid0 = 0, n_fs0 = 0;

  task automatic drive_cycle(input logic hs, input logic vs, input logic [15:0] rgb, input logic rst_v);
    bit   hs_e, vs_e, err;
    pix_t it;
    @(posedge clk_pll);
    #1;
    rst      = rst_v;
    hs_pin   = hs;
    vs_pin   = vs;
    hs_pin_n = ~hs;
    vs_pin_n = ~vs;
    red      = rgb[15:11];
    green    = rgb[10:5];
    blue     = rgb[4:0];
    if (!rst_v) begin
      m_state = 0; m_good = 0; m_h = 0; m_v = 0; m_ecnt = 0;
      m_hseen = 0; m_vseen = 0; m_hsp = 1; m_vsp = 1;
      e_pin   = '0;
      return;
    end
    hs_e  = hs && !m_hsp;
    vs_e  = vs && !m_vsp;
    m_hsp = hs;
    m_vsp = vs;
    err   = (hs_e && m_hseen && m_h != H_TOT - 1) || (vs_e && m_vseen && m_v != V_TOT - 1);
    if (hs_e) m_hseen = 1;
    if (vs_e) m_vseen = 1;
    if (hs_e) m_h = 0;
    else if (m_h < H_MX) m_h++;
    if (vs_e) m_v = 0;
    else if (hs_e && m_v < V_MX) m_v++;
    if (m_state == 0 && vs_e) begin
      m_state = 1;
      m_good  = 0;
    end else if (m_state == 1 && err) begin
      m_state = 0;
    end else if (m_state == 1 && vs_e) begin
      m_good++;
      if (m_good >= LOCK) m_state = 2;
    end else if (m_state == 2 && err) begin
      m_state = 0;
    end
    if (m_h == H_MX || m_v == V_MX) m_state = 0;
    if (err && m_ecnt < 255) m_ecnt++;
    e_pin.lk = (m_state == 2);
    e_pin.er = err;
    e_pin.ec = 8'(m_ecnt);
    if (m_state == 2 && m_h >= H_ST && m_h < H_ST + H_PIX && m_v >= V_ST && m_v < V_ST + V_LN) begin
      it.d = rgb;
      it.x = m_h - H_ST;
      it.y = m_v - V_ST;
      it.t = longint'($time);
      q0.push_back(it);
      q1.push_back(it);
    end
  endtask

  // One frame from the source; optional short line, line count and reset point
  task automatic send_frame(input int n_lines, input int short_line, input int rst_line, input int rst_h);
    int          len, x, y;
    logic [15:0] rgb;
    for (int v = 0; v < n_lines; v++) begin
      len = (v == short_line) ? H_TOT - 1 : H_TOT;
      for (int h = 0; h < len; h++) begin
        x = h - H_ST;
        y = v - V_ST;
        if (x >= 0 && x < H_PIX && y >= 0 && y < V_LN)
          rgb = {5'(x), 6'(x), 5'(y)};
        else
          rgb = 16'($urandom);
        drive_cycle(h < H_SY, v < V_SY, rgb, !(v == rst_line && h == rst_h));
      end
    end
  endtask

  task automatic mon_one(input string nm, input logic pv, input logic [15:0] pd,
                         input logic [XB-1:0] px, input logic [YB-1:0] py, input logic fs,
                         input logic lk, input logic se, input logic [7:0] ec,
                         input bit has, input pix_t it);
    check({nm, ".locked"}, 32'(lk), 32'(e2.lk));
    check({nm, ".sync_err"}, 32'(se), 32'(e2.er));
    check({nm, ".err_count"}, 32'(ec), 32'(e2.ec));
    if (pv) begin
      if (!has) begin
        check({nm, ".unexpected_pixel"}, 32'd1, 32'd0);
      end else begin
        check({nm, ".data"}, 32'(pd), 32'(it.d));
        check({nm, ".x"}, 32'(px), 32'(it.x));
        check({nm, ".y"}, 32'(py), 32'(it.y));
        check({nm, ".frame_start"}, 32'(fs), 32'(it.x == 0 && it.y == 0));
        check({nm, ".latency"}, 32'(longint'($time) - it.t), 32'(LAT));
      end
    end else begin
      check({nm, ".frame_start_idle"}, 32'(fs), 32'd0);
    end
  endtask

  task automatic rst_one(input string nm, input logic pv, input logic [15:0] pd,
                         input logic [XB-1:0] px, input logic [YB-1:0] py, input logic fs,
                         input logic lk, input logic se, input logic [7:0] ec);
    check({nm, ".rst_valid"}, 32'(pv), 32'd0);
    check({nm, ".rst_data"}, 32'(pd), 32'd0);
    check({nm, ".rst_xy"}, 32'({px, py}), 32'd0);
    check({nm, ".rst_flags"}, 32'({fs, lk, se}), 32'd0);
    check({nm, ".rst_err_count"}, 32'(ec), 32'd0);
  endtask

  always @(posedge clk_pll) begin
    rst_q <= rst;
    e1    <= e_pin;
    e2    <= e1;
  end

  always @(negedge clk_pll) begin
    pix_t it0, it1;
    bit   h0, h1;
    if (!rst_q) begin
      rst_one("dut0", pv0, pd0, px0, py0, fs0, lk0, se0, ec0);
      rst_one("dut1", pv1, pd1, px1, py1, fs1, lk1, se1, ec1);
      q0.delete();
      q1.delete();
    end else begin
      h0 = 0;
      h1 = 0;
      it0 = '{16'h0, 0, 0, 0};
      it1 = '{16'h0, 0, 0, 0};
      if (pv0 && q0.size() > 0) begin it0 = q0.pop_front(); h0 = 1; end
      if (pv1 && q1.size() > 0) begin it1 = q1.pop_front(); h1 = 1; end
      mon_one("dut0", pv0, pd0, px0, py0, fs0, lk0, se0, ec0, h0, it0);
      mon_one("dut1", pv1, pd1, px1, py1, fs1, lk1, se1, ec1, h1, it1);
      if (pv0) n_valid0++;
      if (fs0) n_fs0++;
    end
  end

  initial begin
    int snap_v, snap_fs;
    repeat (4) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // nominal: lock at the second checked vs edge, third frame fully captured
    send_frame(V_TOT, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("f2.locked", 32'(lk0), 32'd0);
    snap_v  = n_valid0;
    snap_fs = n_fs0;
    send_frame(V_TOT, -1, -1, -1);
    check("f3.locked", 32'(lk0), 32'd1);
    check("f3.valid_count", 32'(n_valid0 - snap_v), 32'(H_PIX * V_LN));
    check("f3.frame_starts", 32'(n_fs0 - snap_fs), 32'd1);
    send_frame(V_TOT, -1, -1, -1);

    // one short line while locked, then relock
    send_frame(V_TOT, 5, -1, -1);
    check("short_line.err_count", 32'(ec0), 32'd1);
    check("short_line.locked", 32'(lk0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("short_line.relock_pending", 32'(lk0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    check("short_line.relocked", 32'(lk0), 32'd1);

    // one frame short by a line
    send_frame(V_TOT - 1, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("short_frame.err_count", 32'(ec0), 32'd2);
    check("short_frame.locked", 32'(lk0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("short_frame.relock_pending", 32'(lk0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    check("short_frame.relocked", 32'(lk0), 32'd1);

    // hsync removed: horizontal counter saturates, no wrap
    repeat (40) drive_cycle(1'b0, 1'b0, 16'($urandom), 1'b1);
    check("idle.h_cnt0", 32'(dut0.h_cnt_reg), 32'(H_MX));
    check("idle.h_cnt1", 32'(dut1.h_cnt_reg), 32'(H_MX));
    check("idle.locked", 32'(lk0), 32'd0);
    check("idle.valid", 32'(pv0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    check("idle.err_count", 32'(ec0), 32'd3);
    send_frame(V_TOT, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("idle.relocked", 32'(lk0), 32'd1);
    check("idle.relocked_n", 32'(lk1), 32'd1);

    // reset pulse in the middle of an active line
    send_frame(V_TOT, -1, 5, 7);
    check("rst.err_count", 32'(ec0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    send_frame(V_TOT, -1, -1, -1);
    check("rst.relock_pending", 32'(lk0), 32'd0);
    send_frame(V_TOT, -1, -1, -1);
    check("rst.relocked", 32'(lk0), 32'd1);
    check("rst.relocked_n", 32'(lk1), 32'd1);
    check("rst.err_count_after", 32'(ec1), 32'd0);

    repeat (4) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("q0.left", 32'(q0.size()), 32'd0);
    check("q1.left", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
